cmsdk_mcu_ahb_resp_mux: RTL and testbench

// - Response-side companion to the peripheral address decoder (0x4000_0000..0x4000_AFFF, 4 KB per port).
// - Registers the decoder's one-hot hsel in the address phase and steers hreadyout/hresp/hrdata from the selected

---
 rtl/cmsdk_mcu_ahb_pkg.sv | 30 +++
 rtl/cmsdk_mcu_ahb_default_slave.sv | 79 +++++++
 rtl/cmsdk_mcu_ahb_resp_mux.sv | 109 ++++++++++
 tb/tb_cmsdk_mcu_ahb_resp_mux.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_mcu_ahb_pkg.sv
// Shared definitions for the peripheral-region AHB response path.
//   - NUM_PORTS and the index of each decoded peripheral port
//   - default-slave FSM state encoding
//   - width of the default-slave error counter
package cmsdk_mcu_ahb_pkg;

  localparam int NUM_PORTS = 11;

  // Port indices, one 4 KB window each starting at 0x4000_0000.
  localparam int PORT_GPIO0     = 0;
  localparam int PORT_GPIO1     = 1;
  localparam int PORT_UART0     = 2;
  localparam int PORT_UART1     = 3;
  localparam int PORT_TIMER0    = 4;
  localparam int PORT_TIMER1    = 5;
  localparam int PORT_DUALTIMER = 6;
  localparam int PORT_WDOG      = 7;
  localparam int PORT_I2C       = 8;
  localparam int PORT_SPI       = 9;
  localparam int PORT_SG90      = 10;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/cmsdk_mcu_ahb_default_slave.sv
// Default slave for unmapped accesses inside the peripheral region.
// Answers each captured unmapped NONSEQ/SEQ transfer with the standard
// two-cycle AHB ERROR response and counts those responses (saturating).
//   hclk         in   AHB clock
//   hreset       in   synchronous active-high reset
//   def_capture  in   unmapped transfer accepted this cycle (address phase, hready=1)
//   ds_hreadyout out  ready while the default slave owns the data phase
//   ds_hresp     out  response while the default slave owns the data phase
//   err_cnt      out  saturating number of ERROR responses started
module cmsdk_mcu_ahb_default_slave
  import cmsdk_mcu_ahb_pkg::*;
#(
  parameter bit DEFAULT_ERR = 1'b1
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 def_capture,
  output logic                 ds_hreadyout,
  output logic                 ds_hresp,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ds_state_t state;
  ds_state_t state_nxt;
  logic      enter_err1;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= DS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // With DEFAULT_ERR=0 no transition ever leaves DS_IDLE, so the default
  // slave degenerates into a zero-wait OKAY responder.
  always_comb begin
    state_nxt    = state;
    ds_hreadyout = 1'b1;
    ds_hresp     = 1'b0;
    case (state)
      DS_IDLE: begin
        if (def_capture && DEFAULT_ERR) begin
          state_nxt = DS_ERR1;
        end
      end
      DS_ERR1: begin
        ds_hreadyout = 1'b0;
        ds_hresp     = 1'b1;
        state_nxt    = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hreadyout = 1'b1;
        ds_hresp     = 1'b1;
        // The ERR2 cycle has hready=1, so a following unmapped access is
        // accepted here and chains straight into another ERROR.
        if (def_capture && DEFAULT_ERR) begin
          state_nxt = DS_ERR1;
        end else begin
          state_nxt = DS_IDLE;
        end
      end
      default: begin
        state_nxt = DS_IDLE;
      end
    endcase
  end

  assign enter_err1 = (state_nxt == DS_ERR1) && (state != DS_ERR1);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_cnt <= '0;
    end else if (enter_err1 && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmsdk_mcu_ahb_resp_mux.sv
// AHB response multiplexer for the peripheral region (0x4000_0000..0x4000_AFFF).
// Registers the decoder's one-hot port select in the address phase and
// steers hreadyout/hresp/hrdata of the selected port back to the master in
// the data phase. Unmapped transfers go to an internal default slave.
//   hclk         in   AHB clock
//   hreset       in   synchronous active-high reset
//   hsel         in   peripheral-region select from the system decoder
//   htrans       in   AHB transfer type (bit1 = NONSEQ/SEQ)
//   hready       in   bus hready (this block's hreadyout fed back)
//   s_hsel       in   one-hot port selects, bit i = port i
//   s_hreadyout  in   per-port ready
//   s_hresp      in   per-port response (1 = ERROR)
//   s_hrdata     in   per-port read data, port i at [32*i+31:32*i]
//   hreadyout    out  muxed ready
//   hresp        out  muxed response
//   hrdata       out  muxed read data
//   err_cnt      out  saturating count of default-slave ERROR responses
module cmsdk_mcu_ahb_resp_mux #(
  parameter int                   NUM_PORTS   = cmsdk_mcu_ahb_pkg::NUM_PORTS,
  parameter logic [NUM_PORTS-1:0] PORT_EN     = {NUM_PORTS{1'b1}},
  parameter bit                   DEFAULT_ERR = 1'b1
) (
  input  logic                                    hclk,
  input  logic                                    hreset,
  input  logic                                    hsel,
  input  logic [1:0]                              htrans,
  input  logic                                    hready,
  input  logic [NUM_PORTS-1:0]                    s_hsel,
  input  logic [NUM_PORTS-1:0]                    s_hreadyout,
  input  logic [NUM_PORTS-1:0]                    s_hresp,
  input  logic [32*NUM_PORTS-1:0]                 s_hrdata,
  output logic                                    hreadyout,
  output logic                                    hresp,
  output logic [31:0]                             hrdata,
  output logic [cmsdk_mcu_ahb_pkg::ERR_CNT_W-1:0] err_cnt
);

  logic [NUM_PORTS-1:0] port_raw;
  logic [NUM_PORTS-1:0] port_hit;
  logic                 def_hit;
  logic [NUM_PORTS:0]   dsel_p1;
  logic                 ds_hreadyout;
  logic                 ds_hresp;
  logic                 unused_htrans0;

  // Keeps the lowest set bit so a malformed multi-hot select still yields a
  // single owner of the data phase.
  function automatic logic [NUM_PORTS-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // IDLE and BUSY are treated alike; only the active/inactive split matters.
  assign unused_htrans0 = htrans[0];

  // ---- address phase ----
  // Mapped ports are captured for any htrans so IDLE/BUSY still get their
  // zero-wait OKAY from the port itself; only active transfers to holes
  // reach the default slave.
  assign port_raw = s_hsel & PORT_EN & {NUM_PORTS{hsel}};
  assign port_hit = lowest_set(port_raw);
  assign def_hit  = hsel & htrans[1] & ~(|port_hit);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_p1 <= '0;
    end else if (hready) begin
      dsel_p1 <= {def_hit, port_hit};
    end
  end

  cmsdk_mcu_ahb_default_slave #(
    .DEFAULT_ERR (DEFAULT_ERR)
  ) u_default_slave (
    .hclk         (hclk),
    .hreset       (hreset),
    .def_capture  (def_hit & hready),
    .ds_hreadyout (ds_hreadyout),
    .ds_hresp     (ds_hresp),
    .err_cnt      (err_cnt)
  );

  // ---- data phase ----
  // dsel_p1 is one-hot or zero, so at most one branch below fires.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dsel_p1[i]) begin
        hreadyout = s_hreadyout[i];
        hresp     = s_hresp[i];
        hrdata    = s_hrdata[32*i +: 32];
      end
    end
    if (dsel_p1[NUM_PORTS]) begin
      hreadyout = ds_hreadyout;
      hresp     = ds_hresp;
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_resp_mux.sv
module tb_cmsdk_mcu_ahb_resp_mux;

  localparam int NP = 11;

  logic            hclk = 1'b0;
  logic            hreset;
  logic            hsel;
  logic [1:0]      htrans;
  logic [NP-1:0]   s_hsel;
  logic [NP-1:0]   s_hreadyout;
  logic [NP-1:0]   s_hresp;
  logic [32*NP-1:0] s_hrdata;

  logic hready, hreadyout, hresp;
  logic [31:0] hrdata;
  logic [7:0]  err_cnt;
  logic d2_hready, d2_hreadyout, d2_hresp;
  logic [31:0] d2_hrdata;
  logic [7:0]  d2_err_cnt;
  logic d3_hready, d3_hreadyout, d3_hresp;
  logic [31:0] d3_hrdata;
  logic [7:0]  d3_err_cnt;

  assign hready    = hreadyout;
  assign d2_hready = d2_hreadyout;
  assign d3_hready = d3_hreadyout;

  always #5 hclk = ~hclk;

  cmsdk_mcu_ahb_resp_mux dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hready(hready),
    .s_hsel(s_hsel), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .err_cnt(err_cnt)
  );

  cmsdk_mcu_ahb_resp_mux #(.PORT_EN(11'h7FE)) dut_pe (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hready(d2_hready),
    .s_hsel(s_hsel), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .hreadyout(d2_hreadyout), .hresp(d2_hresp), .hrdata(d2_hrdata), .err_cnt(d2_err_cnt)
  );

  cmsdk_mcu_ahb_resp_mux #(.DEFAULT_ERR(1'b0)) dut_ok (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hready(d3_hready),
    .s_hsel(s_hsel), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .hreadyout(d3_hreadyout), .hresp(d3_hresp), .hrdata(d3_hrdata), .err_cnt(d3_err_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the data phase (-1 nobody, 0..10 port,
  // 11 default slave), ERROR cycles still owed, and the error tally.
  int          m_tgt;
  int          m_left;
  int          m_cnt;
  logic        exp_ready, exp_resp;
  logic [31:0] exp_data;
  logic [7:0]  exp_cnt;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic addr(input logic hs, input logic [NP-1:0] sh, input logic [1:0] ht);
    hsel   = hs;
    s_hsel = sh;
    htrans = ht;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    s_hrdata[32*i +: 32] = v;
  endtask

  task automatic drive_idle();
    addr(1'b0, '0, 2'b00);
    s_hreadyout = '1;
    s_hresp     = '0;
    s_hrdata    = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    hreset = 1'b1;
    step();
    step();
    hreset = 1'b0;
  endtask

  task automatic model_reset();
    m_tgt  = -1;
    m_left = 0;
    m_cnt  = 0;
  endtask

  task automatic model_eval();
    exp_data = '0;
    exp_cnt  = 8'(m_cnt);
    if (m_tgt < 0) begin
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
    end else if (m_tgt < NP) begin
      exp_ready = s_hreadyout[m_tgt];
      exp_resp  = s_hresp[m_tgt];
      exp_data  = s_hrdata[32*m_tgt +: 32];
    end else begin
      exp_ready = (m_left != 2);
      exp_resp  = (m_left != 0);
    end
  endtask

  task automatic model_update();
    logic [NP-1:0] mask;
    if (hreset) begin
      model_reset();
    end else begin
      if (m_tgt == NP && m_left > 0) m_left--;
      if (exp_ready) begin
        mask  = hsel ? s_hsel : '0;
        m_tgt = -1;
        for (int i = 0; i < NP; i++) begin
          if (mask[i]) begin
            m_tgt = i;
            break;
          end
        end
        if (m_tgt < 0 && hsel && htrans[1]) begin
          m_tgt  = NP;
          m_left = 2;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    hreset = 1'b1;
    step();
    step();
    hreset = 1'b0;
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    // capture port 2, stall it, then reset: the stalled response must vanish
    addr(1'b1, 11'h004, 2'b10);
    step();
    addr(1'b0, '0, 2'b00);
    s_hreadyout[2] = 1'b0;
    set_word(2, 32'h2222_2222);
    settle();
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL reset_pre_stall: got %b want 0", hreadyout); end
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    settle();
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL reset_stall_abandon: got %b want 10", {hreadyout, hresp}); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_stall_hrdata: got %h want 0", hrdata); end
  endtask

  task automatic test_read_port();
    do_reset();
    addr(1'b1, 11'h008, 2'b10);
    step();
    addr(1'b0, '0, 2'b00);
    set_word(3, 32'hDEAD_BEEF);
    set_word(0, 32'h0000_0A0A);
    settle();
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL port3_hrdata: got %h want deadbeef", hrdata); end
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL port3_resp: got %b want 10", {hreadyout, hresp}); end
    // multi-hot select picks the lowest port; port error passes through
    addr(1'b1, 11'h030, 2'b10);
    step();
    addr(1'b0, '0, 2'b00);
    set_word(4, 32'h4444_0004);
    set_word(5, 32'h5555_0005);
    s_hresp[4] = 1'b1;
    settle();
    checks++; if (hrdata !== 32'h4444_0004) begin errors++; $display("FAIL multihot_hrdata: got %h want 44440004", hrdata); end
    checks++; if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL port4_err_pass: got %b want 11", {hreadyout, hresp}); end
    // IDLE to a mapped port is still captured by that port
    s_hresp = '0;
    addr(1'b1, 11'h400, 2'b00);
    step();
    addr(1'b0, '0, 2'b00);
    set_word(10, 32'hAAAA_000A);
    settle();
    checks++; if (hrdata !== 32'hAAAA_000A) begin errors++; $display("FAIL idle_port10_hrdata: got %h want aaaa000a", hrdata); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL idle_port10_err_cnt: got %h want 00", err_cnt); end
  endtask

  task automatic test_unmapped();
    do_reset();
    addr(1'b1, '0, 2'b10);
    step();
    addr(1'b0, '0, 2'b00);
    set_word(0, 32'h1234_5678);
    settle();
    checks++; if ({hreadyout, hresp} !== 2'b01) begin errors++; $display("FAIL unmapped_c1: got %b want 01", {hreadyout, hresp}); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL unmapped_hrdata: got %h want 0", hrdata); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL unmapped_err_cnt: got %h want 01", err_cnt); end
    step();
    checks++; if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL unmapped_c2: got %b want 11", {hreadyout, hresp}); end
    step();
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL unmapped_done: got %b want 10", {hreadyout, hresp}); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL unmapped_err_cnt_hold: got %h want 01", err_cnt); end
  endtask

  task automatic test_port_en();
    do_reset();
    addr(1'b1, 11'h001, 2'b10);
    step();
    addr(1'b0, '0, 2'b00);
    set_word(0, 32'hCAFE_F00D);
    settle();
    checks++; if ({d2_hreadyout, d2_hresp} !== 2'b01) begin errors++; $display("FAIL porten_c1: got %b want 01", {d2_hreadyout, d2_hresp}); end
    checks++; if (d2_hrdata !== 32'h0) begin errors++; $display("FAIL porten_hrdata_c1: got %h want 0", d2_hrdata); end
    checks++; if (d2_err_cnt !== 8'h01) begin errors++; $display("FAIL porten_err_cnt: got %h want 01", d2_err_cnt); end
    checks++; if (hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL porten_full_mask_read: got %h want cafef00d", hrdata); end
    step();
    checks++; if ({d2_hreadyout, d2_hresp} !== 2'b11) begin errors++; $display("FAIL porten_c2: got %b want 11", {d2_hreadyout, d2_hresp}); end
    checks++; if (d2_hrdata !== 32'h0) begin errors++; $display("FAIL porten_hrdata_c2: got %h want 0", d2_hrdata); end
    step();
    checks++; if ({d2_hreadyout, d2_hresp, d2_hrdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL porten_done: got %b/%h want 10/0", {d2_hreadyout, d2_hresp}, d2_hrdata); end
  endtask

  task automatic test_default_okay();
    do_reset();
    addr(1'b1, '0, 2'b10);
    step();
    addr(1'b1, '0, 2'b11);
    set_word(0, 32'h0BAD_0BAD);
    settle();
    checks++; if ({d3_hreadyout, d3_hresp} !== 2'b10) begin errors++; $display("FAIL okay_c1: got %b want 10", {d3_hreadyout, d3_hresp}); end
    checks++; if (d3_hrdata !== 32'h0) begin errors++; $display("FAIL okay_hrdata: got %h want 0", d3_hrdata); end
    step();
    addr(1'b0, '0, 2'b00);
    settle();
    checks++; if ({d3_hreadyout, d3_hresp} !== 2'b10) begin errors++; $display("FAIL okay_c2: got %b want 10", {d3_hreadyout, d3_hresp}); end
    checks++; if (d3_err_cnt !== 8'h00) begin errors++; $display("FAIL okay_err_cnt: got %h want 00", d3_err_cnt); end
  endtask

  task automatic test_wait_state();
    do_reset();
    addr(1'b1, 11'h020, 2'b10);
    step();
    s_hreadyout[5] = 1'b0;
    s_hreadyout[1] = 1'b0;
    set_word(5, 32'h55AA_1234);
    set_word(1, 32'h1111_1111);
    addr(1'b1, 11'h002, 2'b10);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if ({hreadyout, hresp} !== 2'b00) begin errors++; $display("FAIL wait_stall_%0d: got %b want 00", c, {hreadyout, hresp}); end
      step();
    end
    s_hreadyout[5] = 1'b1;
    addr(1'b0, '0, 2'b00);
    settle();
    checks++; if ({hreadyout, hrdata} !== {1'b1, 32'h55AA_1234}) begin errors++; $display("FAIL wait_complete: got %b/%h want 1/55aa1234", hreadyout, hrdata); end
    step();
    checks++; if ({hreadyout, hrdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wait_port1_not_captured: got %b/%h want 1/0", hreadyout, hrdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    addr(1'b1, '0, 2'b10);
    step();
    addr(1'b1, 11'h080, 2'b10);
    set_word(7, 32'h7777_0007);
    settle();
    checks++; if ({hreadyout, hresp} !== 2'b01) begin errors++; $display("FAIL b2b_err1: got %b want 01", {hreadyout, hresp}); end
    step();
    checks++; if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL b2b_err2: got %b want 11", {hreadyout, hresp}); end
    step();
    addr(1'b0, '0, 2'b00);
    settle();
    checks++; if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h7777_0007}) begin errors++; $display("FAIL b2b_port7: got %b/%h want 10/77770007", {hreadyout, hresp}, hrdata); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL b2b_err_cnt: got %h want 01", err_cnt); end
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    do_reset();
    addr(1'b1, '0, 2'b10);
    step();
    for (int k = 0; k < 300; k++) begin
      e = (k + 1 > 255) ? 8'hFF : 8'(k + 1);
      checks++; if ({hreadyout, hresp} !== 2'b01) begin errors++; $display("FAIL sat_err1_%0d: got %b want 01", k, {hreadyout, hresp}); end
      checks++; if (err_cnt !== e) begin errors++; $display("FAIL sat_cnt_%0d: got %h want %h", k, err_cnt, e); end
      step();
      if (k == 299) addr(1'b0, '0, 2'b00);
      settle();
      checks++; if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL sat_err2_%0d: got %b want 11", k, {hreadyout, hresp}); end
      step();
    end
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL sat_done: got %b want 10", {hreadyout, hresp}); end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_final_cnt: got %h want ff", err_cnt); end
  endtask

  task automatic test_reset_mid_error();
    do_reset();
    addr(1'b1, '0, 2'b10);
    step();
    settle();
    checks++; if ({hreadyout, hresp} !== 2'b01) begin errors++; $display("FAIL rst_err_pre: got %b want 01", {hreadyout, hresp}); end
    hreset = 1'b1;
    addr(1'b0, '0, 2'b00);
    step();
    hreset = 1'b0;
    settle();
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL rst_err_after: got %b want 10", {hreadyout, hresp}); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err_cnt: got %h want 00", err_cnt); end
    step();
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL rst_err_no_tail: got %b want 10", {hreadyout, hresp}); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      step();
      hreset = ($urandom_range(49) == 0);
      hsel   = ($urandom_range(3) != 0);
      htrans = 2'($urandom);
      case ($urandom_range(2))
        0:       s_hsel = '0;
        1:       s_hsel = 11'(1) << $urandom_range(NP - 1);
        default: s_hsel = 11'($urandom);
      endcase
      s_hreadyout = 11'($urandom | $urandom);
      s_hresp     = 11'($urandom & $urandom & $urandom);
      for (int w = 0; w < NP; w++) s_hrdata[32*w +: 32] = $urandom;
      settle();
      model_eval();
      checks++; if (hreadyout !== exp_ready) begin errors++; $display("FAIL rand_hreadyout_%0d: got %b want %b", n, hreadyout, exp_ready); end
      checks++; if (hresp !== exp_resp) begin errors++; $display("FAIL rand_hresp_%0d: got %b want %b", n, hresp, exp_resp); end
      checks++; if (hrdata !== exp_data) begin errors++; $display("FAIL rand_hrdata_%0d: got %h want %h", n, hrdata, exp_data); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL rand_err_cnt_%0d: got %h want %h", n, err_cnt, exp_cnt); end
      model_update();
    end
    hreset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    drive_idle();
    test_reset();
    test_read_port();
    test_unmapped();
    test_port_en();
    test_default_okay();
    test_wait_state();
    test_back_to_back();
    test_saturate();
    test_reset_mid_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
